display_scan_ctrl: RTL

- Parametrised successor to the fixed 8-display driver used by the calculator top.
- Holds an N-digit character buffer written by the calculator core, either by random write or by shift-in at the least significant digit (LSD, position 0).
- Drives N seven-segment displays through one shared segment bus plus one-hot digit enables, with time-multiplexed refresh.
- Supports per-position cursor blink and a selectable output polarity.

---
 rtl/disp_pkg.sv | 30 +++
 rtl/seg7_decoder.sv | 33 +++
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - character codes, seven-segment patterns and buffer entry type
package disp_pkg;

  localparam logic [3:0] CH_MINUS = 4'd10;
  localparam logic [3:0] CH_E     = 4'd11;
  localparam logic [3:0] CH_BLANK = 4'd15;

  // Active-high {g,f,e,d,c,b,a} patterns
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       dp;
    logic [3:0] code;
  } disp_char_t;

  localparam disp_char_t CHAR_BLANK = '{dp: 1'b0, code: CH_BLANK};

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - character code plus decimal point to active-high segment pattern
module seg7_decoder
  import disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  output logic [7:0] raw_o
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    case (code_i)
      4'd0:     pattern = SEG_0;
      4'd1:     pattern = SEG_1;
      4'd2:     pattern = SEG_2;
      4'd3:     pattern = SEG_3;
      4'd4:     pattern = SEG_4;
      4'd5:     pattern = SEG_5;
      4'd6:     pattern = SEG_6;
      4'd7:     pattern = SEG_7;
      4'd8:     pattern = SEG_8;
      4'd9:     pattern = SEG_9;
      CH_MINUS: pattern = SEG_MINUS;
      CH_E:     pattern = SEG_E;
      default:  pattern = SEG_BLANK;
    endcase
  end

  assign raw_o = {dp_i, pattern};

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - N-digit multiplexed seven-segment driver with cursor blink
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        clear_i,
  input  logic                        shift_i,
  input  logic                        wr_en_i,
  input  logic [$clog2(N_DIGITS)-1:0] pos_i,
  input  logic [3:0]                  dig_i,
  input  logic                        dp_in_i,
  input  logic                        blink_en_i,
  input  logic [$clog2(N_DIGITS)-1:0] blink_pos_i,
  output logic [7:0]                  seg_o,
  output logic [N_DIGITS-1:0]         an_o
);

  localparam int PW = $clog2(N_DIGITS);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [7:0]          SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  disp_char_t          chars_q [N_DIGITS];
  disp_char_t          chars_d [N_DIGITS];
  disp_char_t          new_char;
  logic [RW-1:0]       div_cnt_q, div_cnt_d;
  logic [PW-1:0]       scan_idx_q, scan_idx_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [7:0]          raw;
  disp_char_t          cur_char;

  assign new_char = '{dp: dp_in_i, code: dig_i};

  // clear beats shift beats random write; out-of-range positions are dropped
  always_comb begin
    chars_d = chars_q;
    if (clear_i) begin
      for (int i = 0; i < N_DIGITS; i++) chars_d[i] = CHAR_BLANK;
    end else if (shift_i) begin
      for (int i = N_DIGITS - 1; i > 0; i--) chars_d[i] = chars_q[i-1];
      chars_d[0] = new_char;
    end else if (wr_en_i && (int'(pos_i) < N_DIGITS)) begin
      chars_d[pos_i] = new_char;
    end
  end

  always_comb begin
    div_cnt_d  = div_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (div_cnt_q == RW'(REFRESH_DIV - 1)) begin
      div_cnt_d  = '0;
      scan_idx_d = (scan_idx_q == PW'(N_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (blink_en_i) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      phase_d     = phase_q;
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end
    end
  end

  assign cur_char = chars_q[scan_idx_q];

  seg7_decoder u_decoder (
    .code_i (cur_char.code),
    .dp_i   (cur_char.dp),
    .raw_o  (raw)
  );

  // Blink blanks segments only; the digit enable keeps scanning
  always_comb begin
    seg_d = raw;
    if (blink_en_i && phase_q && (scan_idx_q == blink_pos_i)) seg_d = 8'h00;
    an_d = N_DIGITS'(1) << scan_idx_q;
    if (ACTIVE_LOW != 0) begin
      seg_d = ~seg_d;
      an_d  = ~an_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int i = 0; i < N_DIGITS; i++) chars_q[i] <= CHAR_BLANK;
      div_cnt_q   <= '0;
      scan_idx_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      chars_q     <= chars_d;
      div_cnt_q   <= div_cnt_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule
